dobbelsteen_multi_axi: RTL and testbench
========================================

// Module: dobbelsteen_multi_axi
// PURPOSE
//  AXI4-Lite slave holding NUM_DICE independent dice, each 1..SIDES, driven by one shared 16-bit Galois LFSR.
//  Each die has its own tumbling counter that advances while the LFSR enables it during a ROLL phase.
//  A ROLL phase lasts ROLL_CYCLES cycles; when it ends, the dice results are frozen.
//  Results go to readable registers and to a packed output bus for LED/7-seg drivers.
//  Sits behind the PS AXI interconnect as the next-generation dice IP.
// PARAMETERS
//  NUM_DICE     4      number of dice, 1..8
//  SIDES        6      faces per die, 2..15; value width VW = 4 bits
//  ROLL_CYCLES  1024   length of the tumble phase in clocks, >=2
//  ADDR_W       6      AXI address width (byte address)
// PORTS
//  s00_axi_aclk    in   1           single clock
//  s00_axi_areset  in   1           synchronous, active-high reset
//  s00_axi_awaddr  in   ADDR_W      write address
//  s00_axi_awvalid in 1; s00_axi_awready out 1
//  s00_axi_wdata   in   32          write data
//  s00_axi_wstrb   in   4           byte enables
//  s00_axi_wvalid in 1; s00_axi_wready out 1
//  s00_axi_bresp   out  2           write response
//  s00_axi_bvalid out 1; s00_axi_bready in 1
//  s00_axi_araddr  in   ADDR_W      read address
//  s00_axi_arvalid in 1; s00_axi_arready out 1
//  s00_axi_rdata   out  32          read data
//  s00_axi_rresp   out  2           read response
//  s00_axi_rvalid out 1; s00_axi_rready in 1
//  dice_val        out  4*NUM_DICE  packed die values; die i at [4i+3:4i]
//  roll_busy       out  1           high during the ROLL phase
//  irq             out  1           level interrupt: DONE and IRQ_EN
// BEHAVIOUR
//  Reset: all AXI ready/valid=0, resp=0, rdata=0; LFSR=16'hACE1; every die=1; FSM=IDLE; CTRL=0; DONE=0; irq=0.
//  Register map (word addresses):
//   0x00 CTRL   RW  [0] ROLL (write 1 starts a roll, self-clears, reads 0); [1] AUTO; [2] IRQ_EN
//   0x04 STATUS R/W1C  [0] BUSY (RO); [1] DONE (write 1 clears)
//   0x08 SEED   RW  [15:0]; a write loads the LFSR at once; a value of 0 is replaced by 16'hACE1
//   0x0C CFG    RO  {8'd0, ROLL_CYCLES[15:0] clipped, SIDES[3:0], NUM_DICE[3:0]}
//   0x10+4i DIE_i RO  [3:0] value of die i, i<NUM_DICE
//   any other address: reads return 0 with SLVERR (2'b10); writes are ignored and return SLVERR
//  Write channel:
//   - awready and wready pulse together for 1 cycle, only when awvalid and wvalid are both high and bvalid=0.
//   - bvalid rises on the next cycle and holds until bready; one transaction is outstanding at a time.
//   - wstrb is honoured per byte on RW registers.
//  Read channel:
//   - arready pulses for 1 cycle when arvalid=1 and rvalid=0.
//   - rdata/rvalid come 1 cycle later; rvalid holds until rready.
//  LFSR: taps 16'hB400, shifts every clock in every state (free-running entropy).
//  FSM:
//   IDLE -> ROLL on a CTRL.ROLL write. When AUTO=1, IDLE -> ROLL also fires 1 cycle after DONE sets.
//   ROLL: 16-bit counter runs 0..ROLL_CYCLES-1; die i advances when lfsr[i]=1 that cycle.
//   Die advance wraps SIDES -> 1. ROLL -> DONEST when the counter reaches ROLL_CYCLES-1.
//   DONEST: sets DONE and returns to IDLE; takes 1 cycle.
//  Every value in DIE_i and dice_val lies in 1..SIDES.
//  During ROLL, dice_val shows the live tumbling values; DIE_i reads return the last frozen values.
//  A CTRL.ROLL write during ROLL is ignored: the counter is not restarted, and the write still gets OKAY.
//  A DONE clear and a DONE set in the same cycle: set wins.
//  Clearing AUTO during ROLL lets the current roll finish, then the FSM stays in IDLE.
//  A SEED write during ROLL takes effect immediately; the counter is unaffected.
//  Reset mid-roll or mid-transaction: everything returns to reset values on the next edge, with no response emitted.
// TESTING
//  1 Reset, read 0x0C -> CFG={NUM_DICE=4,SIDES=6,ROLL_CYCLES}; DIE_0..3 read 1; STATUS=0; resp OKAY.
//  2 SEED=16'h1234, CTRL=1 -> roll_busy high exactly ROLL_CYCLES cycles; DONE=1; all DIE_i in 1..6;
//    re-seed 16'h1234 and roll -> identical values (golden model).
//  3 IRQ_EN=1 and roll -> irq rises with DONE; write STATUS=2 -> DONE=0 and irq=0 the next cycle.
//  4 AUTO=1 -> back-to-back rolls, 1 idle cycle between them; clear AUTO mid-roll -> exactly one more DONE, then idle.
//  5 Read 0x30 and write 0x3C -> SLVERR, no state change.
//    AW before W by 3 cycles -> no awready until W arrives.
//    rready held low 5 cycles -> rdata stable.
//  6 Assert reset mid-ROLL, with bvalid pending -> next cycle: bvalid=0, roll_busy=0, dice=1, LFSR=16'hACE1.

Source files
------------

// File: rtl/dobbelsteen_multi_axi.sv
// AXI4-Lite dice roller: NUM_DICE tumbling counters gated by a shared 16-bit Galois LFSR.
// A roll tumbles for ROLL_CYCLES clocks, then freezes the results into the DIE_i registers.
module dobbelsteen_multi_axi #(
  parameter int NUM_DICE    = 4,
  parameter int SIDES       = 6,
  parameter int ROLL_CYCLES = 1024,
  parameter int ADDR_W      = 6
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_areset,
  input  logic [ADDR_W-1:0]       s00_axi_awaddr,
  input  logic                    s00_axi_awvalid,
  output logic                    s00_axi_awready,
  input  logic [31:0]             s00_axi_wdata,
  input  logic [3:0]              s00_axi_wstrb,
  input  logic                    s00_axi_wvalid,
  output logic                    s00_axi_wready,
  output logic [1:0]              s00_axi_bresp,
  output logic                    s00_axi_bvalid,
  input  logic                    s00_axi_bready,
  input  logic [ADDR_W-1:0]       s00_axi_araddr,
  input  logic                    s00_axi_arvalid,
  output logic                    s00_axi_arready,
  output logic [31:0]             s00_axi_rdata,
  output logic [1:0]              s00_axi_rresp,
  output logic                    s00_axi_rvalid,
  input  logic                    s00_axi_rready,
  output logic [4*NUM_DICE-1:0]   dice_val,
  output logic                    roll_busy,
  output logic                    irq,
  output logic [1:0]              dbg_state
);

  // Handshakes: a transfer happens on a clock edge where valid and ready are both high;
  // valid holds until accepted, ready is a one-cycle pulse issued only with no response pending.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROLL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_INIT   = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [15:0] RC_LAST     = 16'(ROLL_CYCLES - 1);
  localparam logic [15:0] RC_CLIP     = (ROLL_CYCLES > 65535) ? 16'hFFFF : 16'(ROLL_CYCLES);
  localparam logic [3:0]  SIDES_V     = 4'(SIDES);
  localparam logic [31:0] CFG_WORD    = {8'd0, RC_CLIP, SIDES_V, 4'(NUM_DICE)};

  state_t                   state_q, state_d;
  logic [15:0]              lfsr_q, lfsr_d;
  logic [15:0]              seed_q, seed_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [NUM_DICE-1:0][3:0] dice_q, dice_d;
  logic [NUM_DICE-1:0][3:0] frz_q, frz_d;
  logic                     auto_q, auto_d;
  logic                     irq_en_q, irq_en_d;
  logic                     done_q, done_d;
  logic                     done_pulse_q, done_pulse_d;
  logic                     wr_ready_q, wr_ready_d;
  logic                     bvalid_q, bvalid_d;
  logic [1:0]               bresp_q, bresp_d;
  logic                     arready_q, arready_d;
  logic                     rvalid_q, rvalid_d;
  logic [31:0]              rdata_q, rdata_d;
  logic [1:0]               rresp_q, rresp_d;

  logic                     wr_fire, rd_fire, roll_req, done_clr, wr_ok, rd_ok;
  logic [31:0]              rd_data;
  logic [15:0]              seed_v;
  int                       wr_word, rd_word;
  logic                     unused_bits;

  assign unused_bits = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                         s00_axi_wdata[31:16], s00_axi_wstrb[3:2]};

  // AXI channels and register writes
  always_comb begin
    wr_fire    = wr_ready_q & s00_axi_awvalid & s00_axi_wvalid;
    rd_fire    = arready_q & s00_axi_arvalid;
    wr_word    = int'(s00_axi_awaddr[ADDR_W-1:2]);
    rd_word    = int'(s00_axi_araddr[ADDR_W-1:2]);
    wr_ok      = (wr_word < 4 + NUM_DICE);
    wr_ready_d = s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~wr_ready_q;
    arready_d  = s00_axi_arvalid & ~rvalid_q & ~arready_q;

    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (bvalid_q && s00_axi_bready) bvalid_d = 1'b0;
    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end

    rd_ok   = 1'b1;
    rd_data = '0;
    case (rd_word)
      0: rd_data = {29'd0, irq_en_q, auto_q, 1'b0};
      1: rd_data = {30'd0, done_q, roll_busy};
      2: rd_data = {16'd0, seed_q};
      3: rd_data = CFG_WORD;
      default: begin
        rd_ok = 1'b0;
        for (int i = 0; i < NUM_DICE; i++) begin
          if (rd_word == 4 + i) begin
            rd_ok   = 1'b1;
            rd_data = {28'd0, frz_q[i]};
          end
        end
      end
    endcase

    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s00_axi_rready) rvalid_d = 1'b0;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end

    // LFSR free-runs every cycle; a SEED write replaces this cycle's shift
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    seed_d   = seed_q;
    seed_v   = seed_q;
    auto_d   = auto_q;
    irq_en_d = irq_en_q;
    roll_req = 1'b0;
    done_clr = 1'b0;
    if (wr_fire) begin
      case (wr_word)
        0: if (s00_axi_wstrb[0]) begin
          roll_req = s00_axi_wdata[0];
          auto_d   = s00_axi_wdata[1];
          irq_en_d = s00_axi_wdata[2];
        end
        1: if (s00_axi_wstrb[0]) done_clr = s00_axi_wdata[1];
        2: if (|s00_axi_wstrb[1:0]) begin
          if (s00_axi_wstrb[0]) seed_v[7:0]  = s00_axi_wdata[7:0];
          if (s00_axi_wstrb[1]) seed_v[15:8] = s00_axi_wdata[15:8];
          if (seed_v == 16'h0000) seed_v = LFSR_INIT;
          seed_d = seed_v;
          lfsr_d = seed_v;
        end
        default: ;
      endcase
    end
  end

  // Roll FSM; dice restart from 1 on every roll so a given seed reproduces its result
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dice_d       = dice_q;
    frz_d        = frz_q;
    done_pulse_d = 1'b0;
    done_d       = done_q;
    if (done_clr) done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (roll_req || (auto_q && done_pulse_q)) begin
          state_d = ST_ROLL;
          cnt_d   = 16'd0;
          for (int i = 0; i < NUM_DICE; i++) dice_d[i] = 4'd1;
        end
      end
      ST_ROLL: begin
        for (int i = 0; i < NUM_DICE; i++) begin
          if (lfsr_q[i]) dice_d[i] = (dice_q[i] == SIDES_V) ? 4'd1 : dice_q[i] + 4'd1;
        end
        if (cnt_q == RC_LAST) state_d = ST_DONE;
        else                  cnt_d   = cnt_q + 16'd1;
      end
      ST_DONE: begin
        frz_d        = dice_q;
        done_d       = 1'b1;
        done_pulse_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= LFSR_INIT;
      seed_q       <= LFSR_INIT;
      cnt_q        <= 16'd0;
      dice_q       <= {NUM_DICE{4'd1}};
      frz_q        <= {NUM_DICE{4'd1}};
      auto_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      wr_ready_q   <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'd0;
      rresp_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      seed_q       <= seed_d;
      cnt_q        <= cnt_d;
      dice_q       <= dice_d;
      frz_q        <= frz_d;
      auto_q       <= auto_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
      wr_ready_q   <= wr_ready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
    end
  end

  assign s00_axi_awready = wr_ready_q;
  assign s00_axi_wready  = wr_ready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;
  assign roll_busy       = (state_q == ST_ROLL);
  assign irq             = done_q & irq_en_q;
  assign dice_val        = dice_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_dobbelsteen_multi_axi.sv
// Bench for dobbelsteen_multi_axi: directed AXI traffic, scoreboard on the R/B channels,
// and an independent dice/LFSR model for roll results.
module tb_dobbelsteen_multi_axi;

  localparam int RC = 100;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [31:0] CFG    = {8'd0, 16'd100, 4'd6, 4'd4};

  logic        clk = 1'b0;
  logic        areset;
  logic [5:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp, dbg_state;
  logic [15:0] dice_val;
  logic        roll_busy, irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  exp_rresp_q[$];
  logic [1:0]  exp_bresp_q[$];
  int busy_run = 0, idle_run = 0, last_busy_len = 0, last_gap = 0, done_rolls = 0;

  dobbelsteen_multi_axi #(.NUM_DICE(4), .SIDES(6), .ROLL_CYCLES(RC), .ADDR_W(6)) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(areset),
    .s00_axi_awaddr(awaddr), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .dice_val(dice_val), .roll_busy(roll_busy), .irq(irq), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // golden model
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // The roll starts three LFSR shifts after the SEED write lands, given back-to-back
  // axi_write calls (load edge, B handshake edge, next AW/W ready edge, handshake edge).
  function automatic logic [15:0] model_roll(input logic [15:0] seed);
    logic [15:0] l;
    logic [3:0]  d[4];
    l = (seed == 16'h0000) ? 16'hACE1 : seed;
    for (int k = 0; k < 3; k++) l = lfsr_step(l);
    for (int i = 0; i < 4; i++) d[i] = 4'd1;
    for (int j = 0; j < RC; j++) begin
      for (int i = 0; i < 4; i++) if (l[i]) d[i] = (d[i] == 4'd6) ? 4'd1 : d[i] + 4'd1;
      l = lfsr_step(l);
    end
    return {d[3], d[2], d[1], d[0]};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!areset) begin
      if (rvalid && rready) begin
        if (exp_q.size() == 0) timeout_fail("unexpected_r");
        else begin
          check("rdata", rdata, exp_q.pop_front());
          check("rresp", {30'd0, rresp}, {30'd0, exp_rresp_q.pop_front()});
        end
      end
      if (bvalid && bready) begin
        if (exp_bresp_q.size() == 0) timeout_fail("unexpected_b");
        else check("bresp", {30'd0, bresp}, {30'd0, exp_bresp_q.pop_front()});
      end
    end
  end

  // roll_busy run-length tracker
  always @(negedge clk) begin
    if (roll_busy) begin
      if (busy_run == 0) last_gap = idle_run;
      idle_run = 0;
      busy_run++;
    end else begin
      if (busy_run > 0) begin
        last_busy_len = busy_run;
        busy_run = 0;
        done_rolls++;
      end
      idle_run++;
    end
  end

  // driver tasks
  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
    int t = 0;
    exp_bresp_q.push_back(exp_resp);
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    if (!awready) begin
      timeout_fail("aw_ready");
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!bvalid && t < 50);
    if (!bvalid) timeout_fail("bvalid");
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [5:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    int t = 0;
    exp_q.push_back(exp_data);
    exp_rresp_q.push_back(exp_resp);
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    if (!arready) begin
      timeout_fail("ar_ready");
      arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!rvalid && t < 50);
    if (!rvalid) timeout_fail("rvalid");
    @(posedge clk); #1;
  endtask

  task automatic wait_busy_fall(input string name);
    int t = 0;
    do begin @(negedge clk); t++; end while (roll_busy && t < RC + 50);
    if (roll_busy) timeout_fail(name);
  endtask

  task automatic seed_and_roll(input logic [15:0] seed, output logic [15:0] exp_dice);
    exp_dice = model_roll(seed);
    axi_write(6'h08, {16'd0, seed}, 4'hF, OKAY);
    axi_write(6'h00, 32'h1, 4'hF, OKAY);
    check("busy_start", roll_busy, 1'b1);
  endtask

  task automatic check_roll_result(input logic [15:0] exp_dice);
    logic [3:0] nib;
    wait_busy_fall("roll_end");
    @(posedge clk); #1;
    check("busy_len", last_busy_len, RC);
    check("dice_val", dice_val, exp_dice);
    for (int i = 0; i < 4; i++) begin
      nib = dice_val[4*i +: 4];
      check("die_range", (nib >= 4'd1 && nib <= 4'd6), 1'b1);
    end
    for (int i = 0; i < 4; i++) axi_read(6'(16 + 4*i), {28'd0, exp_dice[4*i +: 4]}, OKAY);
    axi_read(6'h04, 32'h2, OKAY);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [15:0] exp_a, exp_b;
    int t;
    int rolls_before;
    areset = 1'b1; awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0;
    wdata = '0; wstrb = '0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", awready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_dice", dice_val, 16'h1111);
    check("rst_irq", irq, 1'b0);
    @(posedge clk); #1;
    areset = 1'b0;

    // 1: reset register contents
    axi_read(6'h0C, CFG, OKAY);
    for (int i = 0; i < 4; i++) axi_read(6'(16 + 4*i), 32'h1, OKAY);
    axi_read(6'h04, 32'h0, OKAY);
    axi_read(6'h00, 32'h0, OKAY);
    axi_read(6'h08, 32'hACE1, OKAY);

    // 2: seeded rolls, seed 0 substitution, reproducibility, ignored mid-roll ROLL write
    seed_and_roll(16'h1234, exp_a);
    check_roll_result(exp_a);
    seed_and_roll(16'h0000, exp_b);
    check_roll_result(exp_b);
    seed_and_roll(16'h1234, exp_a);
    repeat (20) @(negedge clk);
    axi_write(6'h00, 32'h1, 4'hF, OKAY);
    check_roll_result(exp_a);

    // 3: interrupt
    axi_write(6'h04, 32'h2, 4'hF, OKAY);
    axi_write(6'h00, 32'h5, 4'hF, OKAY);
    check("irq_during_roll", irq, 1'b0);
    wait_busy_fall("irq_roll");
    check("irq_in_donest", irq, 1'b0);
    @(posedge clk); #1;
    check("irq_set", irq, 1'b1);
    axi_read(6'h04, 32'h2, OKAY);
    axi_write(6'h04, 32'h2, 4'hF, OKAY);
    check("irq_cleared", irq, 1'b0);
    axi_read(6'h04, 32'h0, OKAY);

    // 4: AUTO back-to-back; busy low for DONEST plus one IDLE cycle between rolls
    rolls_before = done_rolls;
    axi_write(6'h00, 32'h3, 4'hF, OKAY);
    wait_busy_fall("auto_first");
    t = 0;
    do begin @(negedge clk); t++; end while (!roll_busy && t < 10);
    if (!roll_busy) timeout_fail("auto_restart");
    @(posedge clk); #1;
    check("auto_gap", last_gap, 2);
    repeat (10) @(negedge clk);
    axi_write(6'h00, 32'h0, 4'hF, OKAY);
    wait_busy_fall("auto_last");
    repeat (20) @(negedge clk);
    check("auto_stopped", roll_busy, 1'b0);
    check("auto_idle_state", dbg_state, 2'd0);
    check("auto_roll_count", done_rolls - rolls_before, 2);
    axi_read(6'h04, 32'h2, OKAY);

    // 5: bad addresses, AW ahead of W, partial strobes, stalled R channel
    axi_read(6'h30, 32'h0, SLVERR);
    axi_write(6'h3C, 32'h1, 4'hF, SLVERR);
    check("bad_wr_no_roll", roll_busy, 1'b0);
    axi_read(6'h00, 32'h0, OKAY);
    exp_bresp_q.push_back(OKAY);
    @(negedge clk);
    awaddr = 6'h08; wdata = 32'h0000BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("aw_early_awready", awready, 1'b0);
      check("aw_early_wready", wready, 1'b0);
    end
    wvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!awready && t < 20);
    check("aw_late_awready", awready, 1'b1);
    check("aw_late_wready", wready, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!bvalid && t < 20);
    if (!bvalid) timeout_fail("aw_late_bvalid");
    @(posedge clk); #1;
    axi_read(6'h08, 32'h0000BEEF, OKAY);
    axi_write(6'h08, 32'h00001200, 4'b0010, OKAY);
    axi_read(6'h08, 32'h000012EF, OKAY);
    exp_q.push_back(CFG);
    exp_rresp_q.push_back(OKAY);
    rready = 1'b0;
    @(negedge clk);
    araddr = 6'h0C; arvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!arready && t < 20);
    if (!arready) timeout_fail("stall_arready");
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rvalid", rvalid, 1'b1);
      check("stall_rdata", rdata, CFG);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;

    // 6: reset mid-roll with a write response pending
    axi_write(6'h00, 32'h1, 4'hF, OKAY);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    awaddr = 6'h04; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!awready && t < 20);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!bvalid && t < 20);
    check("rst6_bvalid_pending", bvalid, 1'b1);
    check("rst6_busy_before", roll_busy, 1'b1);
    areset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst6_bvalid", bvalid, 1'b0);
    check("rst6_busy", roll_busy, 1'b0);
    check("rst6_dice", dice_val, 16'h1111);
    check("rst6_state", dbg_state, 2'd0);
    @(posedge clk); #1;
    areset = 1'b0;
    bready = 1'b1;
    axi_read(6'h00, 32'h0, OKAY);
    axi_read(6'h04, 32'h0, OKAY);
    axi_read(6'h08, 32'hACE1, OKAY);
    axi_read(6'h10, 32'h1, OKAY);
    seed_and_roll(16'hBEEF, exp_b);
    check_roll_result(exp_b);

    repeat (3) @(negedge clk);
    check("sb_drain", exp_q.size() + exp_bresp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
